// File: rtl/dut_vector_sequencer.sv
// Clocked self-checking harness: drives stored vectors into a combinational dut and streams masked compare results.
// Each vector costs SETTLE+1 cycles with res_ready high; a low res_ready freezes the result beat and dut_in.
module dut_vector_sequencer #(
  parameter int IN_W   = 20,
  parameter int OUT_W  = 10,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [IN_W-1:0]   cfg_in,
  input  logic [OUT_W-1:0]  cfg_exp,
  input  logic [OUT_W-1:0]  cfg_mask,
  input  logic [ADDR_W:0]   num_vec,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [IN_W-1:0]   dut_in,
  input  logic [OUT_W-1:0]  dut_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ADDR_W-1:0] res_idx,
  output logic [OUT_W-1:0]  res_data,
  output logic              res_fail,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_fail_idx,
  output logic              any_fail
);

  typedef struct packed {
    logic [IN_W-1:0]  stim;
    logic [OUT_W-1:0] exp;
    logic [OUT_W-1:0] mask;
  } vec_t;

  typedef enum logic [1:0] {IDLE, APPLY, EMIT, DONE} state_t;

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

  vec_t              mem [DEPTH];
  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_inc;
  logic [ADDR_W:0]   n_lat;
  logic [CNT_W-1:0]  settle_cnt;
  logic [OUT_W-1:0]  cur_exp, cur_mask;
  logic [IN_W-1:0]   nxt_stim;
  logic              settle_last, last_vec, mis;
  logic              start_run, start_empty, sample, advance;

  assign idx_inc     = idx + 1'b1;
  assign cur_exp     = mem[idx].exp;
  assign cur_mask    = mem[idx].mask;
  assign nxt_stim    = mem[idx_inc].stim;
  assign settle_last = (settle_cnt == CNT_W'(1));
  assign last_vec    = ({1'b0, idx} == (n_lat - 1'b1));
  assign mis         = |((dut_out ^ cur_exp) & cur_mask);

  // Table storage is deliberately outside the reset domain so contents survive rst.
  always_ff @(posedge clk) begin
    if (cfg_we && !busy) begin
      mem[cfg_addr] <= {cfg_in, cfg_exp, cfg_mask};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (num_vec == '0) ? DONE : APPLY;
      APPLY:   if (settle_last) state_nxt = EMIT;
      EMIT:    if (res_ready) state_nxt = last_vec ? DONE : APPLY;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state == APPLY) || (state == EMIT);
    done        = (state == DONE);
    start_run   = (state == IDLE) && start && (num_vec != '0);
    start_empty = (state == IDLE) && start && (num_vec == '0);
    sample      = (state == APPLY) && settle_last;
    advance     = (state == EMIT) && res_ready && !last_vec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx            <= '0;
      n_lat          <= '0;
      settle_cnt     <= '0;
      dut_in         <= '0;
      res_valid      <= 1'b0;
      res_idx        <= '0;
      res_data       <= '0;
      res_fail       <= 1'b0;
      err_count      <= '0;
      first_fail_idx <= '0;
      any_fail       <= 1'b0;
    end else begin
      if (start_run || start_empty) begin
        err_count      <= '0;
        any_fail       <= 1'b0;
        first_fail_idx <= '0;
      end
      if (start_run) begin
        n_lat      <= (num_vec > DEPTH_V) ? DEPTH_V : num_vec;
        idx        <= '0;
        dut_in     <= mem[0].stim;
        settle_cnt <= CNT_W'(SETTLE);
      end
      if ((state == APPLY) && !settle_last) begin
        settle_cnt <= settle_cnt - 1'b1;
      end
      if (sample) begin
        res_valid <= 1'b1;
        res_data  <= dut_out;
        res_idx   <= idx;
        res_fail  <= mis;
        if (mis) begin
          err_count <= err_count + 1'b1;
          any_fail  <= 1'b1;
          if (!any_fail) first_fail_idx <= idx;
        end
      end
      if ((state == EMIT) && res_ready) begin
        res_valid <= 1'b0;
      end
      if (advance) begin
        idx        <= idx_inc;
        dut_in     <= nxt_stim;
        settle_cnt <= CNT_W'(SETTLE);
      end
    end
  end

endmodule

// File: tb/tb_dut_vector_sequencer.sv
// Randomized bench for dut_vector_sequencer against a table-level reference model.
module tb_dut_vector_sequencer;
  localparam int IN_W   = 20;
  localparam int OUT_W  = 10;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int SETTLE = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_we = 1'b0;
  logic [ADDR_W-1:0] cfg_addr = '0;
  logic [IN_W-1:0]   cfg_in = '0;
  logic [OUT_W-1:0]  cfg_exp = '0;
  logic [OUT_W-1:0]  cfg_mask = '0;
  logic [ADDR_W:0]   num_vec = '0;
  logic              start = 1'b0;
  logic              busy, done;
  logic [IN_W-1:0]   dut_in;
  logic [OUT_W-1:0]  dut_out;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [ADDR_W-1:0] res_idx;
  logic [OUT_W-1:0]  res_data;
  logic              res_fail;
  logic [ADDR_W:0]   err_count;
  logic [ADDR_W-1:0] first_fail_idx;
  logic              any_fail;

  logic [IN_W-1:0]  m_in   [DEPTH];
  logic [OUT_W-1:0] m_exp  [DEPTH];
  logic [OUT_W-1:0] m_mask [DEPTH];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Combinational device under sequencing: fold the stimulus halves together.
  assign dut_out = dut_in[9:0] ^ dut_in[19:10];

  dut_vector_sequencer #(
    .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SETTLE(SETTLE)
  ) u_dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_in(cfg_in), .cfg_exp(cfg_exp), .cfg_mask(cfg_mask),
    .num_vec(num_vec), .start(start), .busy(busy), .done(done),
    .dut_in(dut_in), .dut_out(dut_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx), .res_data(res_data),
    .res_fail(res_fail), .err_count(err_count), .first_fail_idx(first_fail_idx), .any_fail(any_fail)
  );

  function automatic logic [OUT_W-1:0] model_out(input logic [IN_W-1:0] v);
    return v[9:0] ^ v[19:10];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic [IN_W-1:0] v, input logic [OUT_W-1:0] e,
                         input logic [OUT_W-1:0] m);
    cfg_we = 1'b1; cfg_addr = ADDR_W'(i); cfg_in = v; cfg_exp = e; cfg_mask = m;
    step;
    cfg_we = 1'b0;
    m_in[i] = v; m_exp[i] = e; m_mask[i] = m;
  endtask

  task automatic rand_vec(input int i);
    logic [IN_W-1:0]  v;
    logic [OUT_W-1:0] e, m, flip;
    v    = IN_W'($urandom);
    flip = ($urandom_range(0, 2) == 0) ? OUT_W'(1 << $urandom_range(0, 9)) : '0;
    e    = model_out(v) ^ flip;
    m    = ($urandom_range(0, 3) == 0) ? OUT_W'($urandom) : 10'h3FF;
    set_vec(i, v, e, m);
  endtask

  task automatic check_idle_zero(input string pfx);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_dut_in"}, dut_in, 0);
    check({pfx, "_res_valid"}, res_valid, 0);
    check({pfx, "_res_idx"}, res_idx, 0);
    check({pfx, "_res_data"}, res_data, 0);
    check({pfx, "_res_fail"}, res_fail, 0);
    check({pfx, "_err_count"}, err_count, 0);
    check({pfx, "_first_fail"}, first_fail_idx, 0);
    check({pfx, "_any_fail"}, any_fail, 0);
  endtask

  // One complete run: model summary from the table, then observe beats and the done pulse.
  task automatic run(input int nreq, input int ready_pct, input bit stall_first, input bit noise);
    int n, beats, cyc, stalls, exp_err, exp_first, hold_bad, busy_bad;
    bit exp_any, got_done, held;
    logic [OUT_W-1:0]  d, h_data;
    logic              f, h_fail;
    logic [IN_W-1:0]   in_before, h_in;
    logic [ADDR_W-1:0] h_idx;
    n = (nreq > DEPTH) ? DEPTH : nreq;
    exp_err = 0; exp_first = 0; exp_any = 0;
    for (int i = 0; i < n; i++) begin
      if (((model_out(m_in[i]) ^ m_exp[i]) & m_mask[i]) != '0) begin
        if (!exp_any) exp_first = i;
        exp_any = 1;
        exp_err++;
      end
    end
    in_before = dut_in;
    num_vec = (ADDR_W+1)'(nreq);
    start = 1'b1;
    step;
    start = 1'b0;
    num_vec = (ADDR_W+1)'($urandom_range(0, 31));
    if (n != 0) check("start_dut_in", dut_in, m_in[0]);
    beats = 0; cyc = 1; stalls = 0; hold_bad = 0; busy_bad = 0;
    got_done = 0; held = 0;
    h_data = '0; h_fail = 1'b0; h_in = '0; h_idx = '0;
    while (cyc < 1000) begin
      if (done) begin
        got_done = 1;
        break;
      end
      if (busy !== (n != 0)) busy_bad++;
      if (held && res_valid &&
          ({res_data, res_idx, res_fail, dut_in} !== {h_data, h_idx, h_fail, h_in})) hold_bad++;
      if (stall_first && beats == 0 && stalls < 5) res_ready = 1'b0;
      else res_ready = ($urandom_range(0, 99) < ready_pct);
      held = res_valid && !res_ready;
      if (held) begin
        stalls++;
        h_data = res_data; h_idx = res_idx; h_fail = res_fail; h_in = dut_in;
      end
      if (res_valid && res_ready) begin
        if (beats < n) begin
          d = model_out(m_in[beats]);
          f = |((d ^ m_exp[beats]) & m_mask[beats]);
          check("beat_idx", res_idx, beats);
          check("beat_data", res_data, d);
          check("beat_fail", res_fail, f);
          check("beat_dut_in", dut_in, m_in[beats]);
        end
        beats++;
      end
      if (noise) begin
        start    = 1'($urandom_range(0, 1));
        cfg_we   = 1'($urandom_range(0, 1));
        cfg_addr = ADDR_W'($urandom);
        cfg_in   = IN_W'($urandom);
        cfg_exp  = OUT_W'($urandom);
        cfg_mask = OUT_W'($urandom);
      end
      step;
      cyc++;
    end
    start = 1'b0; cfg_we = 1'b0; res_ready = 1'b0;
    check("done_seen", got_done, 1);
    check("done_cycle", cyc, n * (SETTLE + 1) + 1 + stalls);
    check("beat_count", beats, n);
    check("busy_during_run", busy_bad, 0);
    check("emit_hold_stable", hold_bad, 0);
    check("busy_in_done", busy, 0);
    check("err_count", err_count, exp_err);
    check("any_fail", any_fail, exp_any);
    check("first_fail_idx", first_fail_idx, exp_first);
    if (n == 0) check("dut_in_kept", dut_in, in_before);
    step;
    check("done_pulse_width", done, 0);
    check("summary_hold", err_count, exp_err);
  endtask

  initial begin
    logic [IN_W-1:0] v;
    rst = 1'b1;
    step;
    check_idle_zero("reset");
    rst = 1'b0;
    step;

    // Echo-style vectors (upper half zero), idx1 expected value has bit0 wrong.
    for (int i = 0; i < 3; i++) begin
      v = {10'h000, 10'($urandom)};
      set_vec(i, v, v[9:0] ^ ((i == 1) ? 10'h001 : 10'h000), 10'h3FF);
    end
    run(3, 100, 0, 0);
    set_vec(1, m_in[1], m_exp[1], 10'h3FE);
    run(3, 100, 0, 0);
    run(3, 100, 1, 0);
    run(0, 100, 0, 0);

    // Reset in APPLY at idx2 of a 5-vector run, then replay with the table intact.
    for (int i = 0; i < 5; i++) begin
      v = IN_W'($urandom);
      set_vec(i, v, model_out(v) ^ ((i == 0) ? 10'h004 : 10'h000), 10'h3FF);
    end
    num_vec = 5'd5; start = 1'b1; res_ready = 1'b1;
    step;
    start = 1'b0;
    repeat (4) step;
    check("mid_busy", busy, 1);
    check("mid_res_idx", res_idx, 1);
    check("mid_dut_in", dut_in, m_in[2]);
    check("mid_err_count", err_count, 1);
    rst = 1'b1;
    #1;
    check_idle_zero("midrst");
    #1;
    rst = 1'b0;
    res_ready = 1'b0;
    step;
    run(5, 100, 0, 1);

    // Full table, oversized num_vec, start re-pulses and ignored writes during the run.
    for (int i = 0; i < DEPTH; i++) rand_vec(i);
    run(20, 100, 0, 1);

    repeat (8) begin
      repeat ($urandom_range(0, 4)) rand_vec($urandom_range(0, DEPTH - 1));
      run(($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 20), $urandom_range(30, 100),
          1'($urandom_range(0, 1)), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
